// File: rtl/warp_issue_replay.sv
// Warp issue holding stage: latches one warp instruction and replays it to not-yet-accepting cores.
// Optional replay-cycle performance counter enabled by defining REPLAY_PERF_CNT_EN.
module warp_issue_replay #(
  parameter int unsigned NUM_THREADS = 32,
  parameter int unsigned REG_WIDTH   = 32,
  parameter int unsigned MAX_REPLAY  = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [5:0]                       in_opcode,
  input  logic                             in_is_fp,
  input  logic [NUM_THREADS-1:0]           in_mask,
  input  logic [NUM_THREADS*REG_WIDTH-1:0] in_op1_bus,
  input  logic [NUM_THREADS*REG_WIDTH-1:0] in_op2_bus,
  input  logic [NUM_THREADS-1:0]           core_ready,
  output logic                             warp_valid,
  output logic [5:0]                       opcode,
  output logic                             is_fp,
  output logic [NUM_THREADS-1:0]           thread_active,
  output logic [NUM_THREADS*REG_WIDTH-1:0] op1_bus,
  output logic [NUM_THREADS*REG_WIDTH-1:0] op2_bus,
  output logic                             warp_done,
  output logic                             stall_err,
  output logic [31:0]                      perf_replay_cycles
);

  localparam int unsigned BusW = NUM_THREADS * REG_WIDTH;
  localparam int unsigned CntW = (MAX_REPLAY > 0) ? $clog2(MAX_REPLAY + 1) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_REPLAY);

  localparam logic StIdle  = 1'b0;
  localparam logic StIssue = 1'b1;

  logic                   state_q;
  logic [NUM_THREADS-1:0] pending_q;
  logic [5:0]             opcode_q;
  logic                   is_fp_q;
  logic [BusW-1:0]        op1_q;
  logic [BusW-1:0]        op2_q;
  logic                   done_q;
  logic                   stall_q;
  logic [CntW-1:0]        replay_q;
  logic [CntW-1:0]        replay_d;

  logic [NUM_THREADS-1:0] remaining;
  logic                   issuing;
  logic                   replaying;
  logic                   retiring;
  logic                   accept;

  assign remaining = pending_q & ~core_ready;
  assign issuing   = (state_q == StIssue);
  assign replaying = issuing & (|remaining);
  assign retiring  = issuing & ~(|remaining);
  assign in_ready  = ~flush & (~issuing | retiring);
  assign accept    = in_valid & in_ready;

  // Saturating replay count for the current warp.
  always_comb begin
    replay_d = replay_q;
    if (replay_q != MaxCnt) begin
      replay_d = replay_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      opcode_q  <= '0;
      is_fp_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      done_q    <= 1'b0;
      stall_q   <= 1'b0;
      replay_q  <= '0;
    end else if (flush) begin
      // Drop the held warp; stall_err survives until reset.
      state_q   <= StIdle;
      pending_q <= '0;
      done_q    <= 1'b0;
      replay_q  <= '0;
    end else begin
      done_q <= retiring | (accept & ~(|in_mask));
      if (accept) begin
        state_q   <= (|in_mask) ? StIssue : StIdle;
        pending_q <= in_mask;
        opcode_q  <= in_opcode;
        is_fp_q   <= in_is_fp;
        op1_q     <= in_op1_bus;
        op2_q     <= in_op2_bus;
        replay_q  <= '0;
      end else if (replaying) begin
        pending_q <= remaining;
        replay_q  <= replay_d;
        if (replay_d == MaxCnt) begin
          stall_q <= 1'b1;
        end
      end else if (retiring) begin
        state_q   <= StIdle;
        pending_q <= '0;
      end
    end
  end

`ifdef REPLAY_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (replaying && !flush) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_replay_cycles = perf_q;
`else
  assign perf_replay_cycles = '0;
`endif

  assign warp_valid    = issuing;
  assign opcode        = opcode_q;
  assign is_fp         = is_fp_q;
  assign thread_active = pending_q;
  assign op1_bus       = op1_q;
  assign op2_bus       = op2_q;
  assign warp_done     = done_q;
  assign stall_err     = stall_q;

endmodule

// File: tb/tb_warp_issue_replay.sv
// Self-checking bench for warp_issue_replay: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_warp_issue_replay;

  localparam int unsigned NT   = 4;
  localparam int unsigned RW   = 8;
  localparam int unsigned MAXR = 3;
  localparam int unsigned BW   = NT * RW;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_is_fp;
  logic [5:0]    in_opcode;
  logic [NT-1:0] in_mask, core_ready;
  logic [BW-1:0] in_op1_bus, in_op2_bus;
  logic          in_ready, warp_valid, is_fp, warp_done, stall_err;
  logic [5:0]    opcode;
  logic [NT-1:0] thread_active;
  logic [BW-1:0] op1_bus, op2_bus;
  logic [31:0]   perf_replay_cycles;

  int checks = 0;
  int failures = 0;

  // Reference model: the warp currently held, if any, and its bookkeeping.
  bit            m_busy;
  logic [NT-1:0] m_pend;
  logic [5:0]    m_opc;
  bit            m_fp;
  logic [BW-1:0] m_op1, m_op2;
  int            m_rep;
  bit            m_stall, m_done;
  logic [31:0]   m_perf;

  warp_issue_replay #(
    .NUM_THREADS(NT),
    .REG_WIDTH  (RW),
    .MAX_REPLAY (MAXR)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_opcode         (in_opcode),
    .in_is_fp          (in_is_fp),
    .in_mask           (in_mask),
    .in_op1_bus        (in_op1_bus),
    .in_op2_bus        (in_op2_bus),
    .core_ready        (core_ready),
    .warp_valid        (warp_valid),
    .opcode            (opcode),
    .is_fp             (is_fp),
    .thread_active     (thread_active),
    .op1_bus           (op1_bus),
    .op2_bus           (op2_bus),
    .warp_done         (warp_done),
    .stall_err         (stall_err),
    .perf_replay_cycles(perf_replay_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !flush && (!m_busy || ((m_pend & ~core_ready) == '0));
  endfunction

  task automatic check_model();
    logic [31:0] exp_perf;
`ifdef REPLAY_PERF_CNT_EN
    exp_perf = m_perf;
`else
    exp_perf = 32'd0;
`endif
    check_eq("in_ready", 64'(in_ready), 64'(model_ready()));
    check_eq("warp_valid", 64'(warp_valid), 64'(m_busy));
    check_eq("thread_active", 64'(thread_active), 64'(m_pend));
    check_eq("opcode", 64'(opcode), 64'(m_opc));
    check_eq("is_fp", 64'(is_fp), 64'(m_fp));
    check_eq("op1_bus", 64'(op1_bus), 64'(m_op1));
    check_eq("op2_bus", 64'(op2_bus), 64'(m_op2));
    check_eq("warp_done", 64'(warp_done), 64'(m_done));
    check_eq("stall_err", 64'(stall_err), 64'(m_stall));
    check_eq("perf", 64'(perf_replay_cycles), 64'(exp_perf));
  endtask

  task automatic model_step();
    logic [NT-1:0] left;
    bit take;
    if (rst) begin
      m_busy = 0; m_pend = '0; m_opc = '0; m_fp = 0; m_op1 = '0; m_op2 = '0;
      m_rep = 0; m_stall = 0; m_done = 0; m_perf = '0;
    end else if (flush) begin
      m_busy = 0; m_pend = '0; m_done = 0; m_rep = 0;
    end else begin
      take   = in_valid && model_ready();
      left   = m_busy ? (m_pend & ~core_ready) : '0;
      m_done = 0;
      if (m_busy && left != '0) begin
        m_pend = left;
        if (m_rep < int'(MAXR)) m_rep++;
        if (m_rep == int'(MAXR)) m_stall = 1;
        m_perf = m_perf + 32'd1;
      end else if (m_busy) begin
        m_done = 1; m_busy = 0; m_pend = '0;
      end
      if (take) begin
        m_opc = in_opcode; m_fp = in_is_fp; m_op1 = in_op1_bus; m_op2 = in_op2_bus;
        m_pend = in_mask; m_rep = 0; m_busy = (in_mask != '0);
        if (in_mask == '0) m_done = 1;
      end
    end
  endtask

  // Inputs are driven just after posedge; outputs are checked on the negedge.
  task automatic tick();
    @(negedge clk);
    check_model();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [NT-1:0] mask, input logic [NT-1:0] rdy,
                       input bit fl);
    in_valid   = v;
    in_mask    = mask;
    core_ready = rdy;
    flush      = fl;
    in_opcode  = 6'($urandom);
    in_is_fp   = 1'($urandom);
    in_op1_bus = BW'($urandom);
    in_op2_bus = BW'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, '0, 0);
    tick();
    tick();
    rst = 1'b0;

    // Full mask, all ready: single issue cycle, done two cycles after accept.
    drive(1, 4'b1111, 4'b1111, 0);
    #1 check_eq("t1_idle_ready", 64'(in_ready), 64'd1);
    tick();
    drive(0, '0, 4'b1111, 0);
    #1 check_eq("t1_active", 64'(thread_active), 64'hf);
    tick();
    drive(0, '0, 4'b1111, 0);
    #1 check_eq("t1_done", 64'(warp_done), 64'd1);
    check_eq("t1_valid_off", 64'(warp_valid), 64'd0);
    tick();

    // Partial acceptance and replay.
    drive(1, 4'b1011, 4'b0000, 0);
    tick();
    drive(0, '0, 4'b0001, 0);
    #1 check_eq("t2_active0", 64'(thread_active), 64'hb);
    tick();
    drive(0, '0, 4'b1010, 0);
    #1 check_eq("t2_active1", 64'(thread_active), 64'ha);
    tick();
    drive(0, '0, 4'b0000, 0);
    tick();

    // Back-to-back warps without a bubble.
    drive(1, 4'b0001, 4'b0000, 0);
    tick();
    drive(1, 4'b0110, 4'b0001, 0);
    #1 check_eq("t3_b2b_ready", 64'(in_ready), 64'd1);
    tick();
    drive(0, '0, 4'b0110, 0);
    #1 check_eq("t3_b_active", 64'(thread_active), 64'h6);
    check_eq("t3_a_done", 64'(warp_done), 64'd1);
    tick();
    drive(0, '0, 4'b0000, 0);
    tick();

    // Empty mask retires immediately.
    drive(1, 4'b0000, 4'b0000, 0);
    tick();
    drive(0, '0, 4'b0000, 0);
    #1 check_eq("t4_done", 64'(warp_done), 64'd1);
    check_eq("t4_no_valid", 64'(warp_valid), 64'd0);
    tick();

    // Replay timeout.
    drive(1, 4'b0100, 4'b0000, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 4'b0000, 0);
      tick();
    end
    check_eq("t5_stall", 64'(stall_err), 64'd1);
    drive(0, '0, 4'b0100, 0);
    tick();
    drive(0, '0, 4'b0000, 0);
    tick();

    // Flush in the second issue cycle.
    drive(1, 4'b1111, 4'b0000, 0);
    tick();
    drive(0, '0, 4'b0001, 0);
    tick();
    drive(1, 4'b0011, 4'b0010, 1);
    #1 check_eq("t6_flush_ready", 64'(in_ready), 64'd0);
    tick();
    drive(1, 4'b0011, 4'b0000, 0);
    #1 check_eq("t6_flushed", 64'(warp_valid), 64'd0);
    tick();
    drive(0, '0, 4'b0011, 0);
    tick();

    // Reset clears the sticky stall flag.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, '0, '0, 0);
    #1 check_eq("t7_stall_clr", 64'(stall_err), 64'd0);
    tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) != 0), NT'($urandom), NT'($urandom),
            ($urandom_range(0, 15) == 0));
      if ($urandom_range(0, 4) == 0) in_mask = '0;
      if ($urandom_range(0, 3) == 0) core_ready = '1;
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/warp_issue_replay.md
Name: warp_issue_replay

Overview:
- Warp-level issue holding stage directly upstream of the NoC dispatcher.
- Latches one warp instruction (opcode, is_fp, active mask, operand buses) and presents it to the dispatcher every cycle.
- Each cycle, clears the pending bit of every thread whose core accepted. Re-presents the instruction to the remaining threads until none are pending, then retires the warp and accepts the next.

Parameters:
- NUM_THREADS, 32, threads per warp / CUDA cores fed.
- REG_WIDTH, 32, operand width per thread.
- MAX_REPLAY, 255, number of non-completing issue cycles after which stall_err is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard the held warp.
- in_valid  in  1  upstream warp instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_opcode  in  6  opcode.
- in_is_fp  in  1  FPU (1) / ALU (0) select.
- in_mask  in  NUM_THREADS  active-thread mask from the scheduler.
- in_op1_bus  in  NUM_THREADS*REG_WIDTH  operand 1, thread i at [i*REG_WIDTH +: REG_WIDTH].
- in_op2_bus  in  NUM_THREADS*REG_WIDTH  operand 2, same packing.
- core_ready  in  NUM_THREADS  per-core ready; same signal the dispatcher sees.
- warp_valid  out  1  to dispatcher.
- opcode  out  6  to dispatcher.
- is_fp  out  1  to dispatcher.
- thread_active  out  NUM_THREADS  pending mask, to dispatcher.
- op1_bus  out  NUM_THREADS*REG_WIDTH  held operand 1.
- op2_bus  out  NUM_THREADS*REG_WIDTH  held operand 2.
- warp_done  out  1  one-cycle pulse when a warp retires.
- stall_err  out  1  sticky replay-timeout flag.
- perf_replay_cycles  out  32  replay-cycle counter (see Optional Feature).

Behaviour:
- Reset values (rst is synchronous): state=IDLE, all registered outputs 0, pending=0, replay_cnt=0, stall_err=0, perf counter 0.
- Per-cycle terms:
  - accepted = warp_valid & pending & core_ready.
  - remaining = pending & ~core_ready.
- States:
  - IDLE: warp_valid=0.
  - ISSUE: warp_valid=1, thread_active=pending.
- in_ready (combinational) = !flush & (state==IDLE | (state==ISSUE & remaining==0)). Back-to-back warps are supported with no bubble.
- Accept (in_valid & in_ready): next cycle, opcode/is_fp/op buses are the latched inputs, pending=in_mask, replay_cnt=0.
  - If in_mask != 0, state becomes ISSUE.
  - If in_mask == 0, state becomes IDLE and warp_done pulses next cycle with no warp_valid ever asserted.
- Latency: accept at cycle N gives warp_valid=1 at N+1. With all ready, retire is evaluated at N+1 and warp_done=1 at N+2.
- ISSUE, remaining!=0: pending<=remaining, replay_cnt<=replay_cnt+1 (saturating at MAX_REPLAY), operands and opcode held unchanged.
- ISSUE, remaining==0:
  - warp_done<=1 next cycle.
  - If a new accept happens the same cycle, load the new warp (stay ISSUE); otherwise go to IDLE and clear pending.
- stall_err set when replay_cnt reaches MAX_REPLAY. Sticky; cleared only by rst. Dispatch continues regardless.
- flush: highest priority after rst.
  - Next cycle: state=IDLE, pending=0, warp_valid=0, no warp_done.
  - in_ready=0 during the flush cycle; stall_err is retained.
- Operand buses are not zeroed on retire; thread masking is done by the dispatcher via thread_active.
- core_ready bits for non-pending threads are ignored.

Optional Feature:
- Macro REPLAY_PERF_CNT_EN.
- Defined: perf_replay_cycles is a 32-bit counter incremented on every ISSUE cycle with remaining!=0. It wraps at 2^32 and is cleared by rst only (not by flush).
- Undefined: perf_replay_cycles tied to 0 and no counter logic; port list unchanged.

Test Plan:
- NUM_THREADS=4, accept mask=4'b1111, core_ready=4'b1111 -> warp_valid high for 1 cycle, thread_active=4'b1111, warp_done pulses at N+2, no stall_err.
- Mask=4'b1011, core_ready=4'b0001 then 4'b1010 -> thread_active 4'b1011 then 4'b1010, warp_done after second cycle, opcode/operands identical on both cycles, perf_replay_cycles=1 with macro.
- Back-to-back: warp A (mask 4'b0001, ready) while warp B valid -> B's thread_active appears the cycle after A retires, no warp_valid gap, two warp_done pulses.
- Mask=0 accepted -> warp_valid never asserts, warp_done pulses at N+1.
- MAX_REPLAY=3, mask=4'b0100, core_ready=0 for 5 cycles -> stall_err rises after 3rd replay and stays high until rst; then core_ready=4'b0100 -> warp_done.
- flush in the 2nd ISSUE cycle with in_valid=1 -> in_ready=0 that cycle, next cycle warp_valid=0, pending=0, no warp_done; new warp accepted the following cycle.
